// File: rtl/frame_write_arbiter.sv
// Round-robin arbiter granting whole frames from NCH feature-map channels to one frame writer.
// Optional stall timeout/abort is enabled with FRAME_WRITE_ARBITER_TIMEOUT_EN.
module frame_write_arbiter #(
  parameter int WI      = 8,
  parameter int NCH     = 4,
  parameter int WIDTH   = 128,
  parameter int HEIGHT  = 128,
  parameter int TIMEOUT = 1024,
  localparam int CW     = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*WI-1:0] in_din,
  input  logic [NCH-1:0]    in_vld,
  output logic [NCH-1:0]    in_rdy,
  output logic [WI-1:0]     out_din,
  output logic              out_vld,
  output logic [CW-1:0]     out_ch,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int FRAME_SIZE = WIDTH * HEIGHT;
  localparam int PW         = $clog2(FRAME_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a pixel moves on channel c in any cycle where in_vld[c] & in_rdy[c];
  // in_rdy is one-hot on the owning channel only while in XFER, zero otherwise.

  state_t          state;
  logic [CW-1:0]   rr_ptr;
  logic [PW-1:0]   pix_cnt;
  logic            accept;
  logic            grant_found;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   rr_next;
  logic            timeout_hit;
  int              cand;

  assign dbg_state  = state;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign accept     = in_vld[out_ch] & in_rdy[out_ch];
  assign rr_next    = (int'(out_ch) == NCH - 1) ? '0 : out_ch + CW'(1);

  always_comb begin
    in_rdy = '0;
    if (state == XFER) in_rdy[out_ch] = 1'b1;
  end

  // First requester at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NCH; i++) begin
      cand = (int'(rr_ptr) + i) % NCH;
      if (!grant_found && in_vld[cand]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      pix_cnt <= '0;
      out_ch  <= '0;
      out_din <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            out_ch  <= grant_idx;
            pix_cnt <= '0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            out_din <= in_din[int'(out_ch)*WI +: WI];
            out_vld <= 1'b1;
            pix_cnt <= pix_cnt + PW'(1);
            if (pix_cnt == PW'(FRAME_SIZE - 1)) state <= DONE;
          end else if (timeout_hit) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        DONE: begin
          rr_ptr <= rr_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_WRITE_ARBITER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;

  // The TIMEOUT-th consecutive stalled cycle aborts the frame.
  assign timeout_hit = (state == XFER) && !in_vld[out_ch] && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= timeout_hit;
      if (state != XFER || accept || timeout_hit) stall_cnt <= '0;
      else if (!in_vld[out_ch])                   stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign frame_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Directed bench for frame_write_arbiter: single channel, fairness, bubbles, mid-frame reset, stall.
module tb_frame_write_arbiter;
  localparam int WI = 8, NCH = 4, WIDTH = 4, HEIGHT = 2, TIMEOUT = 16, FS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*WI-1:0] in_din;
  logic [NCH-1:0]    in_vld;
  logic [NCH-1:0]    in_rdy;
  logic [WI-1:0]     out_din;
  logic              out_vld;
  logic [1:0]        out_ch;
  logic              frame_done;
  logic              frame_abort;
  logic              busy;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  frame_write_arbiter #(
    .WI(WI), .NCH(NCH), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_din(in_din), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_din(out_din), .out_vld(out_vld), .out_ch(out_ch), .frame_done(frame_done),
    .frame_abort(frame_abort), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int c, input int p);
    return 8'(c * 16 + p);
  endfunction

  task automatic drive_pix(input int p);
    for (int c = 0; c < NCH; c++) in_din[c*WI +: WI] = pix(c, p);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_vld"}, out_vld, 0);
    chk({tag, "_din"}, out_din, 0);
    chk({tag, "_ch"}, out_ch, 0);
    chk({tag, "_rdy"}, in_rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_abort"}, frame_abort, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Starts from IDLE: grant edge, FS pixels (holes insert one idle-valid cycle), DONE, IDLE gap.
  task automatic run_frame(input int ch, input logic [7:0] holes, input logic [3:0] vmask);
    int nvld = 0;
    in_vld = vmask;
    drive_pix(1);
    tick();
    chk("grant_ch", out_ch, ch);
    chk("grant_rdy", in_rdy, 1 << ch);
    chk("grant_busy", busy, 1);
    chk("grant_abort", frame_abort, 0);
    for (int p = 1; p <= FS; p++) begin
      if (holes[p-1]) begin
        in_vld = vmask & ~(4'(1) << ch);
        tick();
        nvld += int'(out_vld);
        chk("hole_vld", out_vld, 0);
        chk("hole_rdy", in_rdy, 1 << ch);
        in_vld = vmask;
      end
      drive_pix(p);
      tick();
      nvld += int'(out_vld);
      chk("pix_vld", out_vld, 1);
      chk("pix_din", out_din, pix(ch, p));
      chk("pix_done", frame_done, (p == FS));
      chk("pix_ch", out_ch, ch);
    end
    chk("done_rdy", in_rdy, 0);
    tick();
    chk("gap_busy", busy, 0);
    chk("gap_done", frame_done, 0);
    chk("gap_vld", out_vld, 0);
    chk("nvld", nvld, FS);
  endtask

  initial begin
    logic seen;
    rst    = 1'b1;
    in_vld = '0;
    in_din = '0;
    tick();
    tick();
    check_reset("rst0");
    rst = 1'b0;

    // Single channel 2, rr_ptr=0.
    run_frame(2, 8'h00, 4'b0100);
    in_vld = '0;
    tick();
    chk("s1_idle", busy, 0);

    // Reset rr_ptr, then fairness between channels 0 and 3.
    rst = 1'b1;
    tick();
    check_reset("rst1");
    rst = 1'b0;
    run_frame(0, 8'h00, 4'b1001);
    run_frame(3, 8'h00, 4'b1001);
    run_frame(0, 8'h00, 4'b1001);
    run_frame(3, 8'h00, 4'b1001);
    in_vld = '0;
    tick();

    // Bubbles on pixels 3 and 6 of channel 1.
    run_frame(1, 8'b0010_0100, 4'b0010);
    in_vld = '0;
    tick();

    // Mid-frame reset after pixel 4 of channel 0 (rr_ptr=2 wraps to 0).
    in_vld = 4'b0001;
    tick();
    chk("mr_grant", out_ch, 0);
    for (int p = 1; p <= 4; p++) begin
      drive_pix(p);
      tick();
      chk("mr_din", out_din, pix(0, p));
    end
    rst    = 1'b1;
    in_vld = '0;
    tick();
    check_reset("mr");
    rst = 1'b0;
    run_frame(1, 8'h00, 4'b1010);
    in_vld = '0;
    tick();

    // Channel 0 stalls after pixel 5 (rr_ptr=2 wraps to 0).
    in_vld = 4'b0001;
    tick();
    chk("to_grant", out_ch, 0);
    for (int p = 1; p <= 5; p++) begin
      drive_pix(p);
      tick();
      chk("to_din", out_din, pix(0, p));
    end
    in_vld = '0;
    seen   = 1'b0;
`ifdef FRAME_WRITE_ARBITER_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      seen |= frame_abort;
    end
    chk("to_early", seen, 0);
    chk("to_still_busy", busy, 1);
    tick();
    chk("to_abort", frame_abort, 1);
    chk("to_idle", busy, 0);
    chk("to_nodone", frame_done, 0);
    run_frame(1, 8'h00, 4'b0011);
`else
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      tick();
      seen |= frame_abort | frame_done | out_vld;
    end
    chk("nt_quiet", seen, 0);
    chk("nt_busy", busy, 1);
    chk("nt_rdy", in_rdy, 4'b0001);
    in_vld = 4'b0001;
    for (int p = 6; p <= FS; p++) begin
      drive_pix(p);
      tick();
      chk("nt_din", out_din, pix(0, p));
      chk("nt_done", frame_done, (p == FS));
    end
    tick();
    chk("nt_idle", busy, 0);
`endif
    in_vld = '0;
    tick();
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
